// File: rtl/image_overlay_pkg.sv
// Shared types for the raster overlay stage: box modes, sync FSM states
// and the 32-bit pixel layout.
package image_overlay_pkg;
  localparam int RGB_W = 10;

  typedef enum logic [1:0] {
    OV_OFF    = 2'd0,
    OV_FILL   = 2'd1,
    OV_BORDER = 2'd2,
    OV_INVERT = 2'd3
  } ov_mode_e;

  typedef enum logic {
    SYNC_WAIT = 1'b0,
    RUN       = 1'b1
  } ov_state_e;

  typedef struct packed {
    logic [1:0]       pad;
    logic [RGB_W-1:0] r;
    logic [RGB_W-1:0] g;
    logic [RGB_W-1:0] b;
  } pixel_t;
endpackage

// File: rtl/image_overlay_gen_box_hit.sv
// Combinational hit test of one raster position against one centred box,
// including the border-only variant.
module overlay_box_hit
  import image_overlay_pkg::*;
#(
  parameter int BOX_W  = 128,
  parameter int BOX_H  = 128,
  parameter int BORDER = 2,
  parameter int POS_W  = 10
) (
  input  logic [POS_W-1:0] row,
  input  logic [POS_W-1:0] col,
  input  logic [POS_W-1:0] ctr_row,
  input  logic [POS_W-1:0] ctr_col,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic             hit
);
  // One guard bit beyond sign so centre + half can never overflow.
  localparam int SW = POS_W + 2;
  localparam logic signed [SW-1:0] HALF_H = SW'(BOX_H / 2);
  localparam logic signed [SW-1:0] HALF_W = SW'(BOX_W / 2);
  localparam logic signed [SW-1:0] BRD    = SW'(BORDER);
  localparam logic signed [SW-1:0] ONE    = SW'(1);

  logic signed [SW-1:0] r, c, r0, r1, c0, c1;
  logic in_box, on_border;

  always_comb begin
    r  = $signed({2'b00, row});
    c  = $signed({2'b00, col});
    r0 = $signed({2'b00, ctr_row}) - HALF_H;
    r1 = $signed({2'b00, ctr_row}) + HALF_H - ONE;
    c0 = $signed({2'b00, ctr_col}) - HALF_W;
    c1 = $signed({2'b00, ctr_col}) + HALF_W - ONE;
    // Clipping is implicit: r/c are always on-screen, edges keep unclipped values.
    in_box    = (r >= r0) && (r <= r1) && (c >= c0) && (c <= c1);
    on_border = ((r - r0) < BRD) || ((r1 - r) < BRD) ||
                ((c - c0) < BRD) || ((c1 - c) < BRD);
    hit = en && (mode != OV_OFF) && in_box && ((mode != OV_BORDER) || on_border);
  end
endmodule

// File: rtl/image_overlay_gen.sv
// Raster tracker plus N_BOX rectangle painter over a valid-qualified pixel
// stream; box settings are latched at start of frame, fixed 2-cycle latency.
module image_overlay_gen
  import image_overlay_pkg::*;
#(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 600,
  parameter int N_BOX    = 2,
  parameter int BOX_W    = 128,
  parameter int BOX_H    = 128,
  parameter int BORDER   = 2,
  parameter int POS_W    = 10
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  input  logic                       i_sof,
  input  logic [31:0]                i_data,
  input  logic [N_BOX-1:0]           i_box_en,
  input  logic [2*N_BOX-1:0]         i_box_mode,
  input  logic [POS_W*N_BOX-1:0]     i_box_row,
  input  logic [POS_W*N_BOX-1:0]     i_box_col,
  input  logic [3*RGB_W*N_BOX-1:0]   i_box_color,
  output logic                       o_valid,
  output logic [31:0]                o_data,
  output logic                       o_sof,
  output logic                       o_sync_err
);
  localparam int STAGES = 2;
  localparam int CW     = 3 * RGB_W;

  ov_state_e state, state_nxt;
  logic [POS_W-1:0] col, row, col_nxt, row_nxt, cur_col, cur_row;
  logic load, apply, adv, sync_err;

  logic [N_BOX-1:0]         sh_en, sel_en, box_hit;
  logic [2*N_BOX-1:0]       sh_mode, sel_mode;
  logic [POS_W*N_BOX-1:0]   sh_row, sh_col, sel_row, sel_col;
  logic [CW*N_BOX-1:0]      sh_color, sel_color;

  logic [STAGES:1]          vld_pipe, sof_pipe, err_pipe;
  logic [N_BOX-1:0]         s1_hit;
  logic [2*N_BOX-1:0]       s1_mode;
  logic [CW*N_BOX-1:0]      s1_color;
  logic [CW-1:0]            s1_rgb, mux_rgb;

  pixel_t in_px;
  logic   pad_unused;
  assign in_px      = pixel_t'(i_data);
  assign pad_unused = |in_px.pad;

  // Position of the current pixel and frame-sync bookkeeping.
  always_comb begin
    state_nxt = state;
    cur_col   = col;
    cur_row   = row;
    col_nxt   = col;
    row_nxt   = row;
    load      = 1'b0;
    apply     = 1'b0;
    adv       = 1'b0;
    sync_err  = 1'b0;
    if (i_valid) begin
      if (i_sof) begin
        load      = 1'b1;
        apply     = 1'b1;
        adv       = 1'b1;
        state_nxt = RUN;
        cur_col   = '0;
        cur_row   = '0;
        sync_err  = (state == RUN) && ((col != '0) || (row != '0));
      end else if (state == RUN) begin
        if ((col == '0) && (row == '0)) begin
          sync_err  = 1'b1;
          state_nxt = SYNC_WAIT;
        end else begin
          apply = 1'b1;
          adv   = 1'b1;
        end
      end
    end
    if (adv) begin
      if (cur_col == POS_W'(H_ACTIVE - 1)) begin
        col_nxt = '0;
        row_nxt = (cur_row == POS_W'(V_ACTIVE - 1)) ? '0 : cur_row + 1'b1;
      end else begin
        col_nxt = cur_col + 1'b1;
        row_nxt = cur_row;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= SYNC_WAIT;
      col      <= '0;
      row      <= '0;
      sh_en    <= '0;
      sh_mode  <= '0;
      sh_row   <= '0;
      sh_col   <= '0;
      sh_color <= '0;
    end else begin
      state <= state_nxt;
      col   <= col_nxt;
      row   <= row_nxt;
      if (load) begin
        sh_en    <= i_box_en;
        sh_mode  <= i_box_mode;
        sh_row   <= i_box_row;
        sh_col   <= i_box_col;
        sh_color <= i_box_color;
      end
    end
  end

  // The sof pixel itself already uses the freshly sampled settings.
  assign sel_en    = load ? i_box_en    : sh_en;
  assign sel_mode  = load ? i_box_mode  : sh_mode;
  assign sel_row   = load ? i_box_row   : sh_row;
  assign sel_col   = load ? i_box_col   : sh_col;
  assign sel_color = load ? i_box_color : sh_color;

  for (genvar k = 0; k < N_BOX; k++) begin : g_box
    overlay_box_hit #(
      .BOX_W(BOX_W), .BOX_H(BOX_H), .BORDER(BORDER), .POS_W(POS_W)
    ) u_hit (
      .row     (cur_row),
      .col     (cur_col),
      .ctr_row (sel_row[k*POS_W +: POS_W]),
      .ctr_col (sel_col[k*POS_W +: POS_W]),
      .en      (sel_en[k]),
      .mode    (sel_mode[2*k +: 2]),
      .hit     (box_hit[k])
    );
  end

  // Lowest index wins: walk from the top so the last assignment is the lowest hit.
  always_comb begin
    mux_rgb = s1_rgb;
    for (int k = N_BOX - 1; k >= 0; k--) begin
      if (s1_hit[k]) begin
        mux_rgb = (s1_mode[2*k +: 2] == OV_INVERT) ? ~s1_rgb : s1_color[k*CW +: CW];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_pipe <= '0;
      sof_pipe <= '0;
      err_pipe <= '0;
      s1_hit   <= '0;
      s1_mode  <= '0;
      s1_color <= '0;
      s1_rgb   <= '0;
      o_data   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1], i_valid};
      sof_pipe <= {sof_pipe[1], i_sof};
      err_pipe <= {err_pipe[1], sync_err};
      s1_hit   <= box_hit & {N_BOX{apply}};
      s1_mode  <= sel_mode;
      s1_color <= sel_color;
      s1_rgb   <= i_valid ? {in_px.r, in_px.g, in_px.b} : '0;
      o_data   <= {2'b00, mux_rgb};
    end
  end

  assign o_valid    = vld_pipe[STAGES];
  assign o_sof      = sof_pipe[STAGES];
  assign o_sync_err = err_pipe[STAGES];
endmodule

// File: tb/tb_image_overlay_gen.sv
// Bench for image_overlay_gen: frame-level reference model with a 2-deep
// expectation queue, plus a table of hand-derived pixel values per scenario.
module tb_image_overlay_gen;
  localparam int H  = 16;
  localparam int V  = 8;
  localparam int BW = 4;
  localparam int BH = 4;
  localparam int BD = 1;
  localparam int NB = 2;
  localparam int PW = 10;

  logic i_clk = 1'b0, i_rst = 1'b0, i_valid = 1'b0, i_sof = 1'b0;
  logic [31:0]      i_data = '0;
  logic [NB-1:0]    i_box_en = '0;
  logic [2*NB-1:0]  i_box_mode = '0;
  logic [PW*NB-1:0] i_box_row = '0, i_box_col = '0;
  logic [30*NB-1:0] i_box_color = '0;
  logic o_valid, o_sof, o_sync_err;
  logic [31:0] o_data;

  image_overlay_gen #(
    .H_ACTIVE(H), .V_ACTIVE(V), .N_BOX(NB), .BOX_W(BW), .BOX_H(BH),
    .BORDER(BD), .POS_W(PW)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_sof(i_sof), .i_data(i_data),
    .i_box_en(i_box_en), .i_box_mode(i_box_mode), .i_box_row(i_box_row),
    .i_box_col(i_box_col), .i_box_color(i_box_color),
    .o_valid(o_valid), .o_data(o_data), .o_sof(o_sof), .o_sync_err(o_sync_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { logic v; logic s; logic e; logic [31:0] d; int r; int c; } exp_t;
  typedef struct { int scen; int r; int c; logic [31:0] d; } vec_t;

  exp_t q[$];
  vec_t tbl[$];
  int n_cmp = 0, n_bad = 0, err_seen = 0;
  logic [31:0] cap [V][H];

  // Reference model state: are we locked to the frame, and linear position.
  bit m_sync = 0;
  int m_pos = 0;
  bit sh_en [NB];
  int sh_mode [NB], sh_row [NB], sh_col [NB];
  logic [29:0] sh_color [NB];

  function automatic logic [31:0] overlay(int r, int c, logic [31:0] d);
    for (int k = 0; k < NB; k++) begin
      int r0, r1, c0, c1;
      bit in_b, on_e;
      r0 = sh_row[k] - BH/2; r1 = sh_row[k] + BH/2 - 1;
      c0 = sh_col[k] - BW/2; c1 = sh_col[k] + BW/2 - 1;
      in_b = (r >= r0) && (r <= r1) && (c >= c0) && (c <= c1);
      on_e = (r - r0 < BD) || (r1 - r < BD) || (c - c0 < BD) || (c1 - c < BD);
      if (sh_en[k] && sh_mode[k] != 0 && in_b && (sh_mode[k] != 2 || on_e))
        return (sh_mode[k] == 3) ? {2'b00, ~d[29:0]} : {2'b00, sh_color[k]};
    end
    return {2'b00, d[29:0]};
  endfunction

  function automatic void model_reset();
    m_sync = 0; m_pos = 0;
    for (int k = 0; k < NB; k++) begin
      sh_en[k] = 0; sh_mode[k] = 0; sh_row[k] = 0; sh_col[k] = 0; sh_color[k] = '0;
    end
  endfunction

  task automatic chk(input string nm, input logic [34:0] act, input logic [34:0] exp,
                     input int r, input int c);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s r=%0d c=%0d got=%h want=%h", nm, r, c, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [31:0] d,
                       input int r, input int c);
    exp_t x, y;
    i_valid = v; i_sof = s; i_data = d;
    x.v = v; x.s = s; x.e = 1'b0; x.d = '0; x.r = r; x.c = c;
    if (v) begin
      if (s) begin
        x.e = m_sync && (m_pos != 0);
        m_sync = 1;
        for (int k = 0; k < NB; k++) begin
          sh_en[k]    = i_box_en[k];
          sh_mode[k]  = int'(i_box_mode[2*k +: 2]);
          sh_row[k]   = int'(i_box_row[PW*k +: PW]);
          sh_col[k]   = int'(i_box_col[PW*k +: PW]);
          sh_color[k] = i_box_color[30*k +: 30];
        end
        x.d = overlay(0, 0, d);
        m_pos = 1;
      end else if (m_sync && m_pos == 0) begin
        x.e = 1'b1; m_sync = 0; x.d = {2'b00, d[29:0]};
      end else if (m_sync) begin
        x.d = overlay(m_pos / H, m_pos % H, d);
        m_pos = (m_pos + 1) % (H * V);
      end else begin
        x.d = {2'b00, d[29:0]};
      end
    end
    q.push_back(x);
    @(posedge i_clk); #1;
    if (o_sync_err) err_seen++;
    if (q.size() >= 2) begin
      y = q.pop_front();
      chk("pix", {o_valid, o_sof, o_sync_err, o_data}, {y.v, y.s, y.e, y.d}, y.r, y.c);
      if (y.v && y.r >= 0) cap[y.r][y.c] = o_data;
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_valid = 1'b0; i_sof = 1'b0; i_data = '0;
    #1;
    chk("rst_out", {o_valid, o_sof, o_sync_err, o_data}, 35'd0, -1, -1);
    q.delete();
    model_reset();
    @(posedge i_clk); #1;
    i_rst = 1'b0;
  endtask

  task automatic set_box(input int k, input bit en, input int mode, input int row,
                         input int col, input logic [29:0] color);
    i_box_en[k] = en;
    i_box_mode[2*k +: 2] = 2'(mode);
    i_box_row[PW*k +: PW] = PW'(row);
    i_box_col[PW*k +: PW] = PW'(col);
    i_box_color[30*k +: 30] = color;
  endtask

  function automatic logic [31:0] pix(int pat, int r, int c);
    if (pat == 0) return 32'h0010_0000 + 32'(r * 256 + c);
    if (pat == 1) return 32'h0;
    return $urandom;
  endfunction

  task automatic run_frame(input bit with_sof, input bit gaps, input int pat);
    for (int i = 0; i < H * V; i++) begin
      drive(1'b1, with_sof && i == 0, pix(pat, i / H, i % H), i / H, i % H);
      if (gaps) drive(1'b0, 1'b0, 32'h0, -1, -1);
    end
    drive(1'b0, 1'b0, 32'h0, -1, -1);
  endtask

  task automatic clear_cap();
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++) cap[r][c] = 32'hDEAD_BEEF;
  endtask

  task automatic check_table(input int scen);
    foreach (tbl[i])
      if (tbl[i].scen == scen)
        chk("tbl", {3'b000, cap[tbl[i].r][tbl[i].c]}, {3'b000, tbl[i].d}, tbl[i].r, tbl[i].c);
  endtask

  initial begin
    // Fill: box0 at (4,4) spans rows/cols 2..5.
    tbl.push_back('{1, 2, 2, 32'h3FF0_0000}); tbl.push_back('{1, 5, 5, 32'h3FF0_0000});
    tbl.push_back('{1, 3, 4, 32'h3FF0_0000}); tbl.push_back('{1, 1, 2, 32'h0010_0102});
    tbl.push_back('{1, 6, 5, 32'h0010_0605}); tbl.push_back('{1, 2, 6, 32'h0010_0206});
    tbl.push_back('{1, 0, 0, 32'h0010_0000});
    // Border box0 at (4,4) under fill box1 at (5,5) spanning rows/cols 3..6.
    tbl.push_back('{2, 3, 3, 32'h000F_FC00}); tbl.push_back('{2, 2, 4, 32'h3FF0_0000});
    tbl.push_back('{2, 6, 6, 32'h000F_FC00}); tbl.push_back('{2, 4, 4, 32'h000F_FC00});
    tbl.push_back('{2, 5, 2, 32'h3FF0_0000}); tbl.push_back('{2, 7, 7, 32'h0010_0707});
    tbl.push_back('{2, 2, 6, 32'h0010_0206});
    // Invert quarter box at the corner, no wrap to the far edges.
    tbl.push_back('{3, 0, 0, 32'h3FFF_FFFF}); tbl.push_back('{3, 1, 1, 32'h3FFF_FFFF});
    tbl.push_back('{3, 0, 1, 32'h3FFF_FFFF}); tbl.push_back('{3, 1, 2, 32'h0});
    tbl.push_back('{3, 2, 1, 32'h0});         tbl.push_back('{3, 7, 15, 32'h0});
    tbl.push_back('{3, 6, 14, 32'h0});        tbl.push_back('{3, 7, 0, 32'h0});
    tbl.push_back('{3, 0, 15, 32'h0});
    // Valid toggling: same geometry as the fill frame.
    tbl.push_back('{4, 2, 2, 32'h3FF0_0000}); tbl.push_back('{4, 5, 5, 32'h3FF0_0000});
    tbl.push_back('{4, 1, 1, 32'h0010_0101}); tbl.push_back('{4, 6, 6, 32'h0010_0606});
    // Mid-frame row change ignored until next sof.
    tbl.push_back('{5, 4, 4, 32'h3FF0_0000}); tbl.push_back('{5, 5, 2, 32'h3FF0_0000});
    tbl.push_back('{5, 1, 4, 32'h0010_0104});
    // Unsynced frame passes through although box0 (row 1) is enabled.
    tbl.push_back('{6, 1, 4, 32'h0010_0104}); tbl.push_back('{6, 0, 3, 32'h0010_0003});

    model_reset();
    #2;
    do_reset();

    set_box(0, 1, 1, 4, 4, 30'h3FF0_0000);
    set_box(1, 0, 0, 0, 0, 30'h0);
    clear_cap(); run_frame(1, 0, 0); check_table(1);

    set_box(0, 1, 2, 4, 4, 30'h3FF0_0000);
    set_box(1, 1, 1, 5, 5, 30'h000F_FC00);
    clear_cap(); run_frame(1, 0, 0); check_table(2);

    set_box(0, 1, 3, 0, 0, 30'h3FF0_0000);
    set_box(1, 0, 1, 5, 5, 30'h000F_FC00);
    clear_cap(); run_frame(1, 0, 1); check_table(3);

    set_box(0, 1, 1, 4, 4, 30'h3FF0_0000);
    clear_cap(); run_frame(1, 1, 0); check_table(4);

    clear_cap();
    for (int i = 0; i < H * V; i++) begin
      if (i == 8) i_box_row[PW-1:0] = PW'(1);
      drive(1'b1, i == 0, pix(0, i / H, i % H), i / H, i % H);
    end
    drive(1'b0, 1'b0, 32'h0, -1, -1);
    check_table(5);

    // Next frame picks up row 1; a stray sof at (3,7) resyncs.
    err_seen = 0;
    for (int i = 0; i < 3 * H + 7; i++)
      drive(1'b1, i == 0, pix(0, i / H, i % H), -1, -1);
    for (int i = 0; i < H * V; i++)
      drive(1'b1, i == 0, pix(0, i / H, i % H), -1, -1);
    drive(1'b0, 1'b0, 32'h0, -1, -1);
    chk("resync_err_cnt", 35'(err_seen), 35'd1, -1, -1);

    err_seen = 0;
    clear_cap(); run_frame(0, 0, 0); check_table(6);
    chk("nosof_err_cnt", 35'(err_seen), 35'd1, -1, -1);

    for (int i = 0; i < 20; i++)
      drive(1'b1, i == 0, pix(0, i / H, i % H), -1, -1);
    do_reset();
    run_frame(0, 0, 0);
    run_frame(1, 0, 0);

    for (int f = 0; f < 5; f++) begin
      for (int k = 0; k < NB; k++)
        set_box(k, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, V - 1)), int'($urandom_range(0, H - 1)), 30'($urandom));
      for (int i = 0; i < H * V; i++) begin
        if ($urandom_range(0, 3) == 0) drive(1'b0, 1'b0, 32'h0, -1, -1);
        drive(1'b1, (i == 0) || (f == 2 && i == 40), $urandom, -1, -1);
        if (i == 60) set_box(0, 1'b1, 1, int'($urandom_range(0, V - 1)), 3, 30'($urandom));
      end
    end
    drive(1'b0, 1'b0, 32'h0, -1, -1);
    drive(1'b0, 1'b0, 32'h0, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
